// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-in/parallel-out receiver.
package sipo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 8;

    // Counter must be able to hold WIDTH itself while the parity bit is awaited.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/sipo_bitcnt.sv
// Bit position counter for sipo; clear+enable together restarts at one.
module sipo_bitcnt
    import sipo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CW    = cnt_width(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          tc
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= en ? CW'(1) : '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    assign tc = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/sipo.sv
// Serial-in/parallel-out receiver, LSB first, with sync realignment.
// Define SIPO_PARITY_EN to append an even-parity bit to every frame.
module sipo
    import sipo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             parity_err,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_n;
    logic [CW-1:0]    count;
    logic [CW-1:0]    wr_idx;
    logic             tc;
    logic             cnt_en;
    logic             cnt_clr;
    logic             capture;
    logic             load_word;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] word_next;

    sipo_bitcnt #(.WIDTH(WIDTH), .CW(CW)) u_bitcnt (
        .clk  (clk),
        .rst  (rst),
        .en   (cnt_en),
        .clr  (cnt_clr),
        .count(count),
        .tc   (tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_en    = 1'b0;
        cnt_clr   = 1'b0;
        capture   = 1'b0;
        load_word = 1'b0;
        if (sync) begin
            // Realign: drop the partial word; a bit on this edge becomes bit 0.
            cnt_clr = 1'b1;
            state_n = IDLE;
            if (din_valid) begin
                cnt_en  = 1'b1;
                capture = 1'b1;
                state_n = DATA;
            end
        end else if (din_valid) begin
            case (state)
                IDLE, DATA: begin
                    capture = 1'b1;
                    if (tc) begin
`ifdef SIPO_PARITY_EN
                        cnt_en    = 1'b1;
                        state_n   = PARITY;
`else
                        cnt_clr   = 1'b1;
                        load_word = 1'b1;
                        state_n   = IDLE;
`endif
                    end else begin
                        cnt_en  = 1'b1;
                        state_n = DATA;
                    end
                end
`ifdef SIPO_PARITY_EN
                PARITY: begin
                    cnt_clr   = 1'b1;
                    load_word = 1'b1;
                    state_n   = IDLE;
                end
`endif
                default: begin
                    cnt_clr = 1'b1;
                    state_n = IDLE;
                end
            endcase
        end
    end

    assign wr_idx = sync ? '0 : count;

    always_comb begin
        word_next = shreg;
        if (capture) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (wr_idx == CW'(i)) word_next[i] = din;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg <= '0;
        end else if (capture) begin
            shreg <= word_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= load_word;
            if (load_word) dout <= word_next;
        end
    end

`ifdef SIPO_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_err <= 1'b0;
        end else if (load_word) begin
            parity_err <= (^shreg) ^ din;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_sipo.sv
// Self-checking bench for sipo: directed scenarios plus randomized traffic
// compared against a bit-queue model of frame assembly.
module tb_sipo;

    localparam int WIDTH = 8;
`ifdef SIPO_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             din = 1'b0;
    logic             din_valid = 1'b0;
    logic             sync = 1'b0;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             parity_err;
    logic             busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: bits of the frame being received, plus last outputs.
    bit               q[$];
    logic [WIDTH-1:0] exp_dout = '0;
    logic             exp_valid = 1'b0;
    logic             exp_perr = 1'b0;

    sipo #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .sync      (sync),
        .dout      (dout),
        .dout_valid(dout_valid),
        .parity_err(parity_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic dv, input logic d, input logic sy);
        bit p;
        exp_valid = 1'b0;
        if (sy) begin
            q.delete();
            if (dv) q.push_back(d);
        end else if (dv) begin
            q.push_back(d);
            if (q.size() == FRAME) begin
                exp_dout = '0;
                p = 1'b0;
                for (int i = 0; i < FRAME; i++) begin
                    if (i < WIDTH) exp_dout[i] = q[i];
                    p = p ^ q[i];
                end
                exp_valid = 1'b1;
`ifdef SIPO_PARITY_EN
                exp_perr = p;
`else
                exp_perr = 1'b0;
`endif
                q.delete();
            end
        end
    endtask

    task automatic step(input logic dv, input logic d, input logic sy);
        din_valid = dv;
        din       = d;
        sync      = sy;
        @(posedge clk);
        #1;
        cyc++;
        model_edge(dv, d, sy);
        check("dout", 32'(dout), 32'(exp_dout));
        check("dout_valid", 32'(dout_valid), 32'(exp_valid));
        check("busy", 32'(busy), 32'(q.size() != 0));
        check("parity_err", 32'(parity_err), 32'(exp_perr));
        din_valid = 1'b0;
        sync      = 1'b0;
    endtask

    task automatic send(input logic [WIDTH-1:0] w, input int gap);
        for (int i = 0; i < WIDTH; i++) begin
            step(1'b1, w[i], 1'b0);
            if (i != WIDTH - 1) begin
                for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom), 1'b0);
            end
        end
    endtask

    task automatic send_par(input logic b);
`ifdef SIPO_PARITY_EN
        step(1'b1, b, 1'b0);
`else
        if (b) begin end
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dout"}, 32'(dout), 32'h0);
        check({tag, "_valid"}, 32'(dout_valid), 32'h0);
        check({tag, "_perr"}, 32'(parity_err), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        int pulse_cyc[$];
        logic [WIDTH-1:0] w;

        // Reset state before any clock edge.
        #2;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // 0xA5, continuous valid.
        send(8'hA5, 0);
        send_par(1'b0);
        check("a5_dout", 32'(dout), 32'hA5);
        check("a5_pulse", 32'(dout_valid), 32'h1);
        step(1'b0, 1'b0, 1'b0);
        check("a5_busy_after", 32'(busy), 32'h0);
        check("a5_pulse_gone", 32'(dout_valid), 32'h0);

        // 0x3C with 3-cycle gaps between bits.
        send(8'h3C, 3);
        send_par(1'b0);
        check("3c_dout", 32'(dout), 32'h3C);
        step(1'b0, 1'b1, 1'b0);

        // Partial word aborted by sync carrying bit 0.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check("sync_busy", 32'(busy), 32'h1);
        check("sync_no_pulse", 32'(dout_valid), 32'h0);
        for (int i = 1; i < WIDTH; i++) step(1'b1, 1'b1, 1'b0);
        send_par(1'b1);
        check("sync_dout", 32'(dout), 32'hFE);

        // Sync arriving together with what would have been the final bit.
        for (int i = 0; i < WIDTH - 1; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check("sync_final_no_pulse", 32'(dout_valid), 32'h0);
        check("sync_final_dout", 32'(dout), 32'hFE);

        // Reset in the middle of 0x55.
        w = 8'h55;
        for (int i = 0; i < 5; i++) step(1'b1, w[i], 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        q.delete();
        exp_dout = '0;
        exp_valid = 1'b0;
        exp_perr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("midrst_hold");
        rst = 1'b1;
        send(8'h0F, 0);
        send_par(1'b0);
        check("post_rst_dout", 32'(dout), 32'h0F);

        // Back-to-back words: pulse spacing equals the frame length.
        for (int k = 1; k <= 3; k++) begin
            w = WIDTH'(k);
            for (int i = 0; i < WIDTH; i++) begin
                step(1'b1, w[i], 1'b0);
                if (dout_valid) pulse_cyc.push_back(cyc);
            end
`ifdef SIPO_PARITY_EN
            step(1'b1, ^w, 1'b0);
            if (dout_valid) pulse_cyc.push_back(cyc);
`endif
            check("b2b_dout", 32'(dout), 32'(k));
        end
        check("b2b_pulses", 32'(pulse_cyc.size()), 32'd3);
        if (pulse_cyc.size() == 3) begin
            check("b2b_gap1", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'(FRAME));
            check("b2b_gap2", 32'(pulse_cyc[2] - pulse_cyc[1]), 32'(FRAME));
        end

`ifdef SIPO_PARITY_EN
        send(8'h07, 0);
        step(1'b1, 1'b1, 1'b0);
        check("par_ok_dout", 32'(dout), 32'h07);
        check("par_ok_err", 32'(parity_err), 32'h0);
        send(8'h07, 0);
        step(1'b1, 1'b0, 1'b0);
        check("par_bad_err", 32'(parity_err), 32'h1);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            step(1'($urandom_range(0, 9) < 7), 1'($urandom), 1'($urandom_range(0, 39) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
